// File: rtl/prince_sbox_cf_reg.sv
// rtl/prince_sbox_cf_reg.sv - glitch-barrier register after the 18 CF cells of a masked PRINCE S-box stage
// Optional PRINCE_CF_SKID_EN adds a registered 2-entry skid buffer.
module prince_sbox_cf_reg #(
    parameter int NUM_CF = 18,
    parameter int STAGES = 4,
    parameter int SH_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CF-1:0] cf_q,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SH_W-1:0]   x_s0,
    output logic [SH_W-1:0]   x_s1,
    output logic [SH_W-1:0]   x_s2,
    output logic [SH_W-1:0]   y_s0,
    output logic [SH_W-1:0]   y_s1,
    output logic [SH_W-1:0]   y_s2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        stage_idx,
    output logic              last,
    output logic              rnd_req
);

    localparam logic [1:0] LAST_IDX = 2'(STAGES - 1);

    logic [NUM_CF-1:0] main_q, main_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        stage_idx_q, stage_idx_d;
    logic              rnd_req_q, rnd_req_d;
    logic              last_q, last_d;
    logic              accept, emit;

`ifdef PRINCE_CF_SKID_EN
    logic [NUM_CF-1:0] skid_q, skid_d;
    logic              skid_full_q, skid_full_d;
    logic              in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;

    // A word arriving while main is stalled parks in skid; emit drains skid first to keep order.
    always_comb begin
        accept      = in_valid && in_ready_q;
        emit        = out_valid_q && out_ready;
        main_d      = main_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        out_valid_d = out_valid_q;
        if (emit) begin
            if (skid_full_q) begin
                main_d      = skid_q;
                skid_full_d = 1'b0;
            end else if (accept) begin
                main_d = cf_q;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (out_valid_q) begin
                skid_d      = cf_q;
                skid_full_d = 1'b1;
            end else begin
                main_d      = cf_q;
                out_valid_d = 1'b1;
            end
        end
        in_ready_d = !skid_full_d;
    end
`else
    always_comb begin
        in_ready    = !out_valid_q || out_ready;
        accept      = in_valid && in_ready;
        emit        = out_valid_q && out_ready;
        main_d      = accept ? cf_q : main_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (emit) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_comb begin
        stage_idx_d = stage_idx_q;
        if (emit) begin
            stage_idx_d = (stage_idx_q == LAST_IDX) ? 2'd0 : stage_idx_q + 2'd1;
        end
        rnd_req_d = accept;
        last_d    = out_valid_d && (stage_idx_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q      <= '0;
            out_valid_q <= 1'b0;
            stage_idx_q <= 2'd0;
            rnd_req_q   <= 1'b0;
            last_q      <= 1'b0;
`ifdef PRINCE_CF_SKID_EN
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            main_q      <= main_d;
            out_valid_q <= out_valid_d;
            stage_idx_q <= stage_idx_d;
            rnd_req_q   <= rnd_req_d;
            last_q      <= last_d;
`ifdef PRINCE_CF_SKID_EN
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            in_ready_q  <= in_ready_d;
`endif
        end
    end

    // Pure rewiring: shares pass through untouched, never combined.
    always_comb begin
        for (int k = 0; k < SH_W; k++) begin
            x_s0[k] = main_q[SH_W*k];
            x_s1[k] = main_q[SH_W*k+1];
            x_s2[k] = main_q[SH_W*k+2];
            y_s0[k] = main_q[3*SH_W+SH_W*k];
            y_s1[k] = main_q[3*SH_W+SH_W*k+1];
            y_s2[k] = main_q[3*SH_W+SH_W*k+2];
        end
    end

    assign out_valid = out_valid_q;
    assign stage_idx = stage_idx_q;
    assign rnd_req   = rnd_req_q;
    assign last      = last_q;

endmodule
